// File: rtl/neuron_layer_sequencer_if.sv
// Signal bundle between the layer sequencer, its input/weight/bias memories,
// the shared neuron MAC and the next layer's result buffer.
interface neuron_layer_sequencer_if #(
  parameter int N    = 10,
  parameter int XA_W = 2,
  parameter int WA_W = 4,
  parameter int OA_W = 2
);
  logic            start;
  logic            busy;
  logic            done;
  logic [XA_W-1:0] x_addr;
  logic [N-1:0]    x_data;
  logic [WA_W-1:0] w_addr;
  logic [N-1:0]    w_data;
  logic [OA_W-1:0] b_addr;
  logic [N-1:0]    b_data;
  logic            nrn_rst;
  logic            nrn_inpt_ready;
  logic [N-1:0]    nrn_w;
  logic [N-1:0]    nrn_x;
  logic [N-1:0]    nrn_b;
  logic [N-1:0]    nrn_out;
  logic            res_we;
  logic [OA_W-1:0] res_addr;
  logic [N-1:0]    res_data;

  modport master (
    input  start, x_data, w_data, b_data, nrn_out,
    output busy, done, x_addr, w_addr, b_addr, nrn_rst, nrn_inpt_ready,
           nrn_w, nrn_x, nrn_b, res_we, res_addr, res_data
  );

  modport slave (
    output start, x_data, w_data, b_data, nrn_out,
    input  busy, done, x_addr, w_addr, b_addr, nrn_rst, nrn_inpt_ready,
           nrn_w, nrn_x, nrn_b, res_we, res_addr, res_data
  );
endinterface

// File: rtl/neuron_layer_sequencer.sv
// Time-multiplexes one neuron MAC over every output of a fully-connected layer.
// States: IDLE, CLEAR (clear neuron, issue pair 0), MAC, DRAIN (last strobe), BIAS, WRITE, DONE.
module neuron_layer_sequencer #(
  parameter int N        = 10,
  parameter int Q        = 8,
  parameter int N_IN     = 4,
  parameter int N_OUT    = 3,
  parameter int ACT_RELU = 0,
  parameter int XA_W     = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int WA_W     = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  parameter int OA_W     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  neuron_layer_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_MAC, S_DRAIN, S_BIAS, S_WRITE, S_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [OA_W-1:0] r_j, w_j_nxt;
  logic [XA_W-1:0] r_k, w_k_nxt;
  logic [XA_W-1:0] w_k_issue;
  logic [WA_W-1:0] w_base;
  logic            w_last_k;
  logic            w_last_j;

  if ((Q >= N) || (N_IN < 1) || (N_OUT < 1)) begin : g_bad_cfg
    $error("neuron_layer_sequencer: invalid Q/N_IN/N_OUT");
  end

  assign w_last_k = (r_k == XA_W'(N_IN - 1));
  assign w_last_j = (r_j == OA_W'(N_OUT - 1));
  assign w_base   = WA_W'(r_j) * WA_W'(N_IN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_j     <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_j     <= w_j_nxt;
      r_k     <= w_k_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_j_nxt     = r_j;
    w_k_nxt     = r_k;
    w_k_issue   = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_CLEAR;
          w_j_nxt     = '0;
        end
      end
      S_CLEAR: begin
        w_k_nxt     = XA_W'(1);
        w_state_nxt = (N_IN == 1) ? S_DRAIN : S_MAC;
      end
      S_MAC: begin
        // Address k goes out while the pair for k-1 is being accumulated.
        w_k_issue = r_k;
        if (w_last_k) w_state_nxt = S_DRAIN;
        else          w_k_nxt     = r_k + XA_W'(1);
      end
      S_DRAIN: w_state_nxt = S_BIAS;
      S_BIAS:  w_state_nxt = S_WRITE;
      S_WRITE: begin
        if (w_last_j) begin
          w_state_nxt = S_DONE;
        end else begin
          w_j_nxt     = r_j + OA_W'(1);
          w_state_nxt = S_CLEAR;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_j_nxt     = '0;
        w_k_nxt     = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strobes are masked during reset so an abandoned layer emits nothing more.
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.done           = (r_state == S_DONE) && !rst;
  assign bus.nrn_rst        = rst || (r_state == S_CLEAR);
  assign bus.nrn_inpt_ready = ((r_state == S_MAC) || (r_state == S_DRAIN)) && !rst;
  assign bus.res_we         = (r_state == S_WRITE) && !rst;

  assign bus.x_addr   = w_k_issue;
  assign bus.w_addr   = w_base + WA_W'(w_k_issue);
  assign bus.b_addr   = r_j;
  assign bus.res_addr = r_j;

  assign bus.nrn_w    = bus.w_data;
  assign bus.nrn_x    = bus.x_data;
  assign bus.nrn_b    = bus.b_data;
  assign bus.res_data = ((ACT_RELU != 0) && bus.nrn_out[N-1]) ? '0 : bus.nrn_out;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Directed bench: three sequencer configurations, each with memory models and a
// behavioural neuron (Q8 MAC plus one-shot bias add after the last strobe).
module tb_neuron_layer_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  neuron_layer_sequencer_if #(.N(10), .XA_W(2), .WA_W(4), .OA_W(2)) ifa();
  neuron_layer_sequencer_if #(.N(10), .XA_W(2), .WA_W(4), .OA_W(2)) ifr();
  neuron_layer_sequencer_if #(.N(10), .XA_W(1), .WA_W(1), .OA_W(1)) ifs();

  neuron_layer_sequencer #(.N(10), .Q(8), .N_IN(4), .N_OUT(3), .ACT_RELU(0))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  neuron_layer_sequencer #(.N(10), .Q(8), .N_IN(4), .N_OUT(3), .ACT_RELU(1))
    dut_r (.clk(clk), .rst(rst), .bus(ifr));
  neuron_layer_sequencer #(.N(10), .Q(8), .N_IN(1), .N_OUT(1), .ACT_RELU(0))
    dut_s (.clk(clk), .rst(rst), .bus(ifs));

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int mac_term(input logic [9:0] w, input logic [9:0] x);
    return (int'($signed(w)) * int'($signed(x))) >>> 8;
  endfunction

  // Memories: one-cycle synchronous read.
  logic [9:0] x_mem [4];
  logic [9:0] w_mem [16];
  logic [9:0] b_mem [4];
  logic [9:0] xs, ws, bs;

  always @(posedge clk) begin
    ifa.x_data <= x_mem[ifa.x_addr];
    ifa.w_data <= w_mem[ifa.w_addr];
    ifa.b_data <= b_mem[ifa.b_addr];
    ifr.x_data <= x_mem[ifr.x_addr];
    ifr.w_data <= w_mem[ifr.w_addr];
    ifr.b_data <= b_mem[ifr.b_addr];
    ifs.x_data <= xs;
    ifs.w_data <= ws;
    ifs.b_data <= bs;
  end

  int acc_a, acc_r, acc_s;
  logic arm_a, arm_r, arm_s;

  always @(posedge clk) begin
    if (ifa.nrn_rst) begin acc_a <= 0; arm_a <= 1'b0; end
    else if (ifa.nrn_inpt_ready) begin acc_a <= acc_a + mac_term(ifa.nrn_w, ifa.nrn_x); arm_a <= 1'b1; end
    else if (arm_a) begin acc_a <= acc_a + int'($signed(ifa.nrn_b)); arm_a <= 1'b0; end
  end
  always @(posedge clk) begin
    if (ifr.nrn_rst) begin acc_r <= 0; arm_r <= 1'b0; end
    else if (ifr.nrn_inpt_ready) begin acc_r <= acc_r + mac_term(ifr.nrn_w, ifr.nrn_x); arm_r <= 1'b1; end
    else if (arm_r) begin acc_r <= acc_r + int'($signed(ifr.nrn_b)); arm_r <= 1'b0; end
  end
  always @(posedge clk) begin
    if (ifs.nrn_rst) begin acc_s <= 0; arm_s <= 1'b0; end
    else if (ifs.nrn_inpt_ready) begin acc_s <= acc_s + mac_term(ifs.nrn_w, ifs.nrn_x); arm_s <= 1'b1; end
    else if (arm_s) begin acc_s <= acc_s + int'($signed(ifs.nrn_b)); arm_s <= 1'b0; end
  end
  assign ifa.nrn_out = acc_a[9:0];
  assign ifr.nrn_out = acc_r[9:0];
  assign ifs.nrn_out = acc_s[9:0];

  // Monitors (sampled on the falling edge).
  logic [3:0] wq_a;
  logic [1:0] xq_a;
  always @(posedge clk) begin wq_a <= ifa.w_addr; xq_a <= ifa.x_addr; end

  int we_a = 0, done_a = 0, clr_a = 0, stb_a = 0, stb_tot_a = 0, j_a = 0, lat_a = 0;
  int we_r = 0, done_r = 0;
  int we_s = 0, done_s = 0, lat_s = 0;
  logic [9:0] res_a [4];
  logic [9:0] res_r [4];
  logic [9:0] res_s;

  always @(negedge clk) begin
    if (rst) begin
      j_a   = 0;
      stb_a = 0;
    end else begin
      if (ifa.nrn_rst) begin clr_a++; stb_a = 0; end
      if (ifa.nrn_inpt_ready) begin
        chk("w_seq", int'(wq_a), j_a * 4 + stb_a);
        chk("x_seq", int'(xq_a), stb_a);
        stb_a++;
        stb_tot_a++;
      end
      if (ifa.res_we) begin
        chk("stb_per_nrn", stb_a, 4);
        chk("res_addr", int'(ifa.res_addr), j_a);
        chk("b_addr", int'(ifa.b_addr), j_a);
        res_a[ifa.res_addr] = ifa.res_data;
        we_a++;
        j_a++;
      end
      if (ifa.done) begin done_a++; lat_a = cyc - t0 + 1; j_a = 0; end
      if (ifr.res_we) begin res_r[ifr.res_addr] = ifr.res_data; we_r++; end
      if (ifr.done) done_r++;
      if (ifs.res_we) begin res_s = ifs.res_data; we_s++; end
      if (ifs.done) begin done_s++; lat_s = cyc - t0 + 1; end
    end
  end

  task automatic start_run(input logic a, input logic r, input logic s);
    @(negedge clk);
    ifa.start = a; ifr.start = r; ifs.start = s;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    ifa.start = 1'b0; ifr.start = 1'b0; ifs.start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((ifa.busy || ifr.busy || ifs.busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(n < max), 1);
  endtask

  int b_we, b_done, b_clr, b_stb, b_we_r;

  initial begin
    ifa.start = 1'b0; ifr.start = 1'b0; ifs.start = 1'b0;
    for (int i = 0; i < 4; i++) begin x_mem[i] = 10'd128; b_mem[i] = 10'd64; end
    for (int i = 0; i < 16; i++) w_mem[i] = 10'd64;
    xs = 10'd256; ws = 10'd256; bs = 10'd0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_we", ifa.res_we, 0);
    chk("rst_stb", ifa.nrn_inpt_ready, 0);
    chk("rst_waddr", int'(ifa.w_addr), 0);
    chk("rst_xaddr", int'(ifa.x_addr), 0);
    chk("rst_baddr", int'(ifa.b_addr), 0);
    chk("rst_nrn_rst", ifa.nrn_rst, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_nrn_rst", ifa.nrn_rst, 0);

    // Uniform layer: 4 * (0.5*0.25) + 0.25 = 0.75 -> 192.
    b_we = we_a; b_done = done_a; b_clr = clr_a; b_stb = stb_tot_a;
    start_run(1'b1, 1'b0, 1'b0);
    wait_idle(100);
    for (int i = 0; i < 3; i++) chk("t1_res", int'(res_a[i]), 192);
    chk("t1_we", we_a - b_we, 3);
    chk("t1_done", done_a - b_done, 1);
    chk("t1_latency", lat_a, 22);
    chk("t1_clears", clr_a - b_clr, 3);
    chk("t1_strobes", stb_tot_a - b_stb, 12);

    // Negative weights on neuron 1: -0.5 + 0.25 = -0.25 -> 10'h3C0; ReLU -> 0.
    for (int i = 4; i < 8; i++) w_mem[i] = 10'h3C0;
    b_we_r = we_r;
    start_run(1'b1, 1'b1, 1'b0);
    wait_idle(100);
    chk("t2_res0", int'(res_a[0]), 192);
    chk("t2_res1", int'(res_a[1]), 'h3C0);
    chk("t2_res2", int'(res_a[2]), 192);
    chk("t2_relu0", int'(res_r[0]), 192);
    chk("t2_relu1", int'(res_r[1]), 0);
    chk("t2_relu2", int'(res_r[2]), 192);
    chk("t2_relu_we", we_r - b_we_r, 3);
    for (int i = 4; i < 8; i++) w_mem[i] = 10'd64;

    // Degenerate 1x1 layer: 1.0 * 1.0 + 0 -> 256.
    start_run(1'b0, 1'b0, 1'b1);
    wait_idle(50);
    chk("t4_res", int'(res_s), 256);
    chk("t4_we", we_s, 1);
    chk("t4_done", done_s, 1);
    chk("t4_latency", lat_s, 5);

    // Reset during MAC of neuron 1 abandons the layer.
    b_we = we_a; b_done = done_a; b_clr = clr_a;
    start_run(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 50 && (clr_a - b_clr) < 2; n++) @(negedge clk);
    chk("t5_reach_n1", clr_a - b_clr, 2);
    repeat (2) @(negedge clk);
    chk("t5_in_mac", ifa.nrn_inpt_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy_after_rst", ifa.busy, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("t5_we", we_a - b_we, 1);
    chk("t5_no_done", done_a - b_done, 0);
    b_we = we_a; b_done = done_a;
    res_a[0] = '0; res_a[1] = '0; res_a[2] = '0;
    start_run(1'b1, 1'b0, 1'b0);
    wait_idle(100);
    for (int i = 0; i < 3; i++) chk("t5_rerun_res", int'(res_a[i]), 192);
    chk("t5_rerun_we", we_a - b_we, 3);
    chk("t5_rerun_done", done_a - b_done, 1);

    // start held and re-pulsed while busy: exactly one layer.
    b_we = we_a; b_done = done_a; b_clr = clr_a;
    @(negedge clk);
    ifa.start = 1'b1;
    repeat (6) @(negedge clk);
    ifa.start = 1'b0;
    @(negedge clk);
    ifa.start = 1'b1;
    for (int n = 0; n < 60 && !ifa.done; n++) @(negedge clk);
    ifa.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_we", we_a - b_we, 3);
    chk("t6_done", done_a - b_done, 1);
    chk("t6_clears", clr_a - b_clr, 3);
    chk("t6_idle", ifa.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/neuron_layer_sequencer.md
Name: neuron_layer_sequencer

Overview:
Time-multiplexes a single shared neuron MAC instance across all output neurons of one fully-connected layer. On start, for each output neuron j the block clears the neuron, streams N_IN weight/input pairs from synchronous-read memories, and triggers the one-shot bias add. It then writes the neuron result, optionally ReLU-clamped, into a result buffer. It sits between the layer input/weight/bias memories and the next layer's input buffer.

Parameters:
N, 10, data word width (signed fixed point, must match neuron N)
Q, 8, fractional bits (informational; neuron applies bias shift)
N_IN, 4, inputs per neuron (>=1)
N_OUT, 3, neurons in layer (>=1)
ACT_RELU, 0, 1 = clamp negative results to 0 before write
XA_W, $clog2(N_IN) min 1, input address width
WA_W, $clog2(N_IN*N_OUT) min 1, weight address width
OA_W, $clog2(N_OUT) min 1, bias/result address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin layer; sampled only in IDLE
busy  out  1  high from the cycle after start accepted until DONE exits
done  out  1  one-cycle pulse after final result write
x_addr  out  XA_W  input-buffer read address (1-cycle read latency)
x_data  in  N  input-buffer read data
w_addr  out  WA_W  weight-memory address = j*N_IN + k
w_data  in  N  weight data
b_addr  out  OA_W  bias-memory address = j
b_data  in  N  bias data
nrn_rst  out  1  neuron accumulator clear
nrn_inpt_ready  out  1  neuron accumulate strobe
nrn_w  out  N  = w_data (combinational pass-through)
nrn_x  out  N  = x_data
nrn_b  out  N  = b_data
nrn_out  in  N  neuron result
res_we  out  1  result write strobe
res_addr  out  OA_W  result address = j
res_data  out  N  nrn_out, or 0 if ACT_RELU and nrn_out[N-1]

Behaviour:
- Reset: state IDLE, j=0, k=0; busy=0, done=0, res_we=0, nrn_inpt_ready=0; all addresses 0. nrn_rst = rst OR (state==CLEAR), so reset mid-layer also clears the neuron. Reset abandons the layer with no further writes and no done.
- States: IDLE, CLEAR, MAC, DRAIN, BIAS, WRITE, DONE.
- IDLE: start=1 -> CLEAR, j=0. start in any other state is ignored.
- CLEAR (1 cycle): nrn_rst=1; issue x_addr=0, w_addr=j*N_IN, b_addr=j; k<=1. If N_IN==1 -> DRAIN, else -> MAC.
- MAC (N_IN-1 cycles): issue x_addr=k, w_addr=j*N_IN+k; nrn_inpt_ready=1 (data of address k-1 now valid). On k==N_IN-1 -> DRAIN, else k++.
- DRAIN (1 cycle): nrn_inpt_ready=1 for last pair; no new address.
- BIAS (1 cycle): nrn_inpt_ready=0; b_addr held at j so nrn_b is stable; neuron adds bias at this edge.
- WRITE (1 cycle): res_we=1, res_addr=j, res_data per ACT_RELU. If j==N_OUT-1 -> DONE, else j++ and -> CLEAR.
- DONE (1 cycle): done=1 -> IDLE.
- b_addr holds j from CLEAR through WRITE.
- Exactly N_IN strobes per neuron, one bias cycle, and no strobe in CLEAR/BIAS/WRITE.
- Latency: start edge to done pulse = N_OUT*(N_IN+3)+1 cycles. busy falls with done.
- Arithmetic: no arithmetic in this block beyond address computation. j*N_IN+k must not exceed N_IN*N_OUT-1 and is computed unsigned in WA_W bits.

Test Plan:
1. N_IN=4, N_OUT=3, all x=128 (0.5), w=64 (0.25), b=64 (0.25), ACT_RELU=0 -> three writes, res_data=192 at addr 0,1,2; done exactly 22 cycles after start.
2. Same config, neuron 1 weights = -64 -> res_data[1]=-64 (10'h3C0); with ACT_RELU=1 -> res_data[1]=0, others 192.
3. Address trace check: w_addr sequence 0..11 with 4-per-neuron grouping; nrn_inpt_ready high exactly 4 cycles per neuron; nrn_rst high exactly once per neuron.
4. N_IN=1, N_OUT=1, x=256, w=256, b=0 -> one write of 256; done 5 cycles after start.
5. rst asserted during MAC of neuron 1 -> busy=0 next cycle, no further res_we, no done; a new start then gives a full correct layer (192 x3).
6. start held high throughout and re-pulsed while busy -> exactly one layer run. A new run begins only from IDLE.
